// File: rtl/rle_run_detect.sv
// rle_run_detect
//   Collapses a stream of words into runs of identical words. Each run is
//   emitted as two beats: the run value (selector=1), then its length
//   (selector=0). A run closes when the word changes, when it reaches
//   MAX_RUN words, or on in_last. The word that closes a run early is
//   parked and starts the next run.
//
// Ports
//   clock      rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   upstream word valid
//   in_data    upstream word
//   in_last    final word of the stream; flushes the open run
//   in_ready   word accepted this cycle (registered; high in IDLE/RUN)
//   out_valid  output beat valid (registered)
//   out_ready  downstream accepts the beat
//   data       run value (meaningful when selector=1)
//   count      run length 1..MAX_RUN (meaningful when selector=0)
//   selector   1 = value beat, 0 = count beat
module rle_run_detect #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned MAX_RUN = 255
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data,
  output logic [COUNT_W-1:0] count,
  output logic               selector
);

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_RUN);
  localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, EMIT_VAL, EMIT_CNT} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   cur, cur_n, pend, pend_n;
  logic [COUNT_W-1:0]  cnt, cnt_n;
  logic                pend_valid, pend_valid_n;
  logic                pend_last, pend_last_n;
  logic                in_ready_n, out_valid_n, selector_n;
  logic [DATA_W-1:0]   data_n;
  logic [COUNT_W-1:0]  count_n;
  logic                in_acc, out_acc;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  always_comb begin
    state_n      = state;
    cur_n        = cur;
    cnt_n        = cnt;
    pend_n       = pend;
    pend_valid_n = pend_valid;
    pend_last_n  = pend_last;

    case (state)
      IDLE: begin
        if (in_acc) begin
          cur_n   = in_data;
          cnt_n   = ONE;
          state_n = in_last ? EMIT_VAL : RUN;
        end
      end
      RUN: begin
        if (in_acc) begin
          if (in_data == cur && cnt < MAX_CNT) begin
            cnt_n   = cnt + ONE;
            state_n = in_last ? EMIT_VAL : RUN;
          end else begin
            // Splitting word is parked; it opens the next run after the count beat.
            pend_n       = in_data;
            pend_valid_n = 1'b1;
            pend_last_n  = in_last;
            state_n      = EMIT_VAL;
          end
        end
      end
      EMIT_VAL: begin
        if (out_acc) state_n = EMIT_CNT;
      end
      EMIT_CNT: begin
        if (out_acc) begin
          if (pend_valid) begin
            cur_n        = pend;
            cnt_n        = ONE;
            pend_valid_n = 1'b0;
            state_n      = pend_last ? EMIT_VAL : RUN;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next-state values so each beat appears
    // the cycle after the transfer that produced it and stays put until taken.
    in_ready_n  = (state_n == IDLE) || (state_n == RUN);
    out_valid_n = (state_n == EMIT_VAL) || (state_n == EMIT_CNT);
    selector_n  = (state_n == EMIT_VAL);
    data_n      = cur_n;
    count_n     = cnt_n;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      selector   <= 1'b0;
      data       <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
      pend_last  <= pend_last_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      selector   <= selector_n;
      data       <= data_n;
      count      <= count_n;
    end
  end

endmodule

// File: doc/rle_run_detect.md
Name: rle_run_detect

Overview:
- Run-length detection stage directly upstream of the RLE output select mux.
- Accepts a stream of 32-bit words and collapses consecutive identical words into runs.
- For each run it emits two output beats: the run value (selector=1), then the run length (selector=0).
- The data, count and selector outputs drive the downstream mux's data, count and selector inputs.

Parameters:
DATA_W, 32, width of input/output data words
COUNT_W, 8, width of run-length count
MAX_RUN, 255, maximum run length before a forced split; must be ≤ 2^COUNT_W-1

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_last  input  1  marks final word of stream; flushes the open run
in_ready  output  1  block can accept a word this cycle
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
data  output  DATA_W  run value (meaningful when selector=1)
count  output  COUNT_W  run length 1..MAX_RUN (meaningful when selector=0)
selector  output  1  1 = value beat, 0 = count beat

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; outputs reset to in_ready=0, out_valid=0, data=0, count=0, selector=0.
  - Internal cur, cnt, pend and pend_last are cleared.
  - Deassertion takes effect at the next clock edge.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_valid, data, count and selector are registered and held stable until accepted.
- States: IDLE, RUN, EMIT_VAL, EMIT_CNT. in_ready=1 only in IDLE and RUN.
- IDLE, on accept:
  - cur<=in_data, cnt<=1.
  - Go to EMIT_VAL if in_last, else RUN.
- RUN, on accept:
  - If in_data==cur and cnt<MAX_RUN: cnt<=cnt+1. Go to EMIT_VAL if in_last, else stay in RUN.
  - Otherwise (data differs, or cnt==MAX_RUN): pend<=in_data, pend_valid<=1, pend_last<=in_last; go to EMIT_VAL.
  - The word that caused the split starts the next run; it is never dropped.
- EMIT_VAL:
  - out_valid=1, selector=1, data=cur.
  - On out_ready, go to EMIT_CNT.
- EMIT_CNT:
  - out_valid=1, selector=0, count=cnt, data holds cur.
  - On out_ready with pend_valid: cur<=pend, cnt<=1, pend_valid<=0. Go to EMIT_VAL if pend_last, else RUN.
  - On out_ready without pend_valid: go to IDLE and drop out_valid.
- Latency:
  - A run's value beat is presented the cycle after the terminating input transfer.
  - Back-to-back count beat follows one cycle after value acceptance if out_ready is held high.
  - Minimum of 2 cycles per run on the output side.
- Stalls:
  - Arbitrary out_ready low holds the beat unchanged.
  - No input is accepted while emitting.
  - No beat is ever duplicated or skipped.
- Count range and width:
  - Count never reads 0 on a valid count beat; never exceeds MAX_RUN.
  - cnt arithmetic is COUNT_W bits; overflow cannot occur because of the MAX_RUN split.
- Boundary cases:
  - Single-word stream (in_last on first word) → value beat then count=1.
  - in_last on a word that differs from cur, or arrives at cnt==MAX_RUN → two runs are emitted; the second has count=1.
  - in_valid low in RUN → cnt is held; no timeout flush.
- Reset mid-operation: any open run, pending word or in-flight beat is discarded; out_valid drops immediately.

Test Plan:
- Stream A,A,A,B(last) with out_ready=1 → beats (sel1,A),(sel0,3),(sel1,B),(sel0,1); then IDLE with in_ready=1.
- Single word 0xDEADBEEF with last → (sel1,0xDEADBEEF),(sel0,1); total 2 beats.
- 300 consecutive copies of 0x5 then last → (sel1,5),(sel0,255),(sel1,5),(sel0,45).
- Stream X,X,Y with out_ready low for 5 cycles during the X value beat → data=X held stable all 5 cycles; in_ready=0 throughout; then (sel0,2) and run Y continues.
- Stream 1,2,3,4 (last), alternating values → 8 beats, each count=1, order 1,2,3,4 preserved.
- Assert resetn low during EMIT_CNT of a pending split → out_valid=0 asynchronously; after release a fresh stream C(last) yields only (sel1,C),(sel0,1).
